display_7seg_reader: RTL and testbench

Receive-side counterpart of the BCD-to-7-segment driver. Samples a multiplexed, common-anode 4-digit display bus (active-low segments plus active-low digit enables), debounces each scan slot and decodes each segment pattern back to BCD. Publishes a complete frame once every digit has been captured. Used as a loopback checker and as a front end for reading external display-driven equipment.

---
 rtl/display_7seg_reader.sv | 182 ++++++++++++++++++
 tb/tb_display_7seg_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_7seg_reader.sv
// Receive-side reader for a multiplexed common-anode 7-segment bus.
// It synchronizes the bus and debounces each scan slot. Each accepted slot is decoded
// back to BCD. A frame is published once every digit has been captured.
module display_7seg_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            segIn,
  input  logic [DIGITS-1:0]     anIn,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic [DIGITS-1:0]     blankMask,
  output logic                  err,
  output logic                  valid
);

  localparam int unsigned SW = DIGITS + 7;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [0:0] {StWait, StLocked} state_e;

  logic [SW-1:0]       sync1_q, s_q, sprev_q;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept;
  logic                same;

  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   an_s;
  logic [3:0]          nib;
  logic                blank, invalid;
  logic                any_zero, multi_zero;
  logic [IW-1:0]       idx;
  logic                capture, publish;

  logic [4*DIGITS-1:0] shadow_q, shadow_m;
  logic [DIGITS-1:0]   shblank_q, shblank_m;
  logic [DIGITS-1:0]   seen_q, seen_m;
  logic                ferr_q;

  // Two-flop synchronizer plus one history stage; resets to the idle (all-ones) bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      s_q     <= '1;
      sprev_q <= '1;
    end else begin
      sync1_q <= {anIn, segIn};
      s_q     <= sync1_q;
      sprev_q <= s_q;
    end
  end

  assign same  = (s_q == sprev_q);
  assign seg_s = s_q[6:0];
  assign an_s  = s_q[SW-1:7];

  // Stability FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count matching samples; fire one accept per stable run, then lock until the bus changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StWait: begin
        if (!same) begin
          cnt_d = '0;
        end else if (cnt_q >= CW'(STABLE_CYCLES - 1)) begin
          accept  = 1'b1;
          state_d = StLocked;
          cnt_d   = CW'(STABLE_CYCLES);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StLocked: begin
        if (!same) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Segment pattern to nibble; 7F is a blank digit, anything unknown is flagged invalid.
  always_comb begin
    nib     = 4'hE;
    blank   = 1'b0;
    invalid = 1'b0;
    unique case (seg_s)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h7F: begin
        nib   = 4'hF;
        blank = 1'b1;
      end
      default: begin
        nib     = 4'hE;
        invalid = 1'b1;
      end
    endcase
  end

  // Find the single active-low enable; more than one active enable is treated as illegal.
  always_comb begin
    any_zero   = 1'b0;
    multi_zero = 1'b0;
    idx        = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (!an_s[k]) begin
        if (any_zero) multi_zero = 1'b1;
        any_zero = 1'b1;
        idx      = IW'(k);
      end
    end
  end

  assign capture = accept && any_zero && !multi_zero;

  // Shadow state with the digit being captured merged in.
  always_comb begin
    shadow_m               = shadow_q;
    shadow_m[idx*4 +: 4]   = nib;
    shblank_m              = shblank_q;
    shblank_m[idx]         = blank;
    seen_m                 = seen_q;
    seen_m[idx]            = 1'b1;
  end

  assign publish = capture && (&seen_m);

  // Capture digits into the shadow frame and publish when every digit has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      shblank_q <= '0;
      seen_q    <= '0;
      ferr_q    <= 1'b0;
      bcdOut    <= '0;
      blankMask <= '0;
      err       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= publish;
      if (capture) begin
        shadow_q  <= shadow_m;
        shblank_q <= shblank_m;
        if (publish) begin
          bcdOut    <= shadow_m;
          blankMask <= shblank_m;
          err       <= ferr_q | invalid;
          seen_q    <= '0;
          ferr_q    <= 1'b0;
        end else begin
          seen_q <= seen_m;
          ferr_q <= ferr_q | invalid;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_7seg_reader.sv
// Scoreboard bench for display_7seg_reader: a run-length reference model predicts frames,
// and a monitor checks every published frame, its timing, and output hold between frames.
module tb_display_7seg_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;
  localparam int          LAT    = 2 + STABLE + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segIn = 7'h7F;
  logic [3:0]  anIn = 4'hF;
  logic [15:0] bcdOut;
  logic [3:0]  blankMask;
  logic        err, valid;

  display_7seg_reader #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .segIn     (segIn),
    .anIn      (anIn),
    .bcdOut    (bcdOut),
    .blankMask (blankMask),
    .err       (err),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        err;
    int          at;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference model state: one pin-level run, plus the partially collected frame.
  logic [10:0] run_val = 11'h7FF;
  int          run_len = 1000;
  int          run_start = 0;
  logic [3:0]  m_nib[4];
  logic [3:0]  m_blank;
  logic [3:0]  m_seen;
  logic        m_ferr;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_clear();
    m_seen  = '0;
    m_ferr  = 1'b0;
    m_blank = '0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
  endtask

  // A stable slot with exactly one active enable writes one digit of the frame.
  task automatic model_accept(input logic [10:0] v);
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  nib;
    logic        bl, inv;
    int          k;
    frame_t      f;
    an  = v[10:7];
    seg = v[6:0];
    if ($countones(~an) != 1) return;
    k = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) k = i;
    nib = 4'hE; bl = 1'b0; inv = 1'b1;
    for (int d = 0; d < 10; d++) if (pat[d] == seg) begin nib = 4'(d); inv = 1'b0; end
    if (seg == 7'h7F) begin nib = 4'hF; bl = 1'b1; inv = 1'b0; end
    m_nib[k]   = nib;
    m_blank[k] = bl;
    m_ferr     = m_ferr | inv;
    m_seen[k]  = 1'b1;
    if (m_seen == 4'hF) begin
      for (int i = 0; i < 4; i++) f.bcd[4*i +: 4] = m_nib[i];
      f.blank = m_blank;
      f.err   = m_ferr;
      f.at    = run_start + LAT;
      exp_q.push_back(f);
      m_seen = '0;
      m_ferr = 1'b0;
    end
  endtask

  // Drive the bus for one cycle and advance the run-length model.
  task automatic pins(input logic [3:0] an, input logic [6:0] seg);
    logic [10:0] v;
    @(posedge clk);
    #1;
    anIn  = an;
    segIn = seg;
    v = {an, seg};
    if (v == run_val) begin
      run_len++;
    end else begin
      run_val   = v;
      run_len   = 1;
      run_start = cyc;
    end
    if (run_len == STABLE + 1) model_accept(v);
  endtask

  task automatic scan(input logic [3:0] an, input logic [6:0] seg, input int hold);
    repeat (hold) pins(an, seg);
  endtask

  task automatic idle(input int n);
    scan(4'hF, 7'h7F, n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    anIn  = 4'hF;
    segIn = 7'h7F;
    run_val = 11'h7FF;
    run_len = 1000;
    model_clear();
    @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bcdOut), 32'h0);
    chk("reset_blank", 32'(blankMask), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    rst = 1'b0;
  endtask

  // Monitor: pop on every valid, otherwise outputs must hold the last published frame.
  logic [15:0] h_bcd = '0;
  logic [3:0]  h_blank = '0;
  logic        h_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      h_bcd = '0; h_blank = '0; h_err = 1'b0;
    end else if (!done) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(valid), 32'h0);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk("frame_bcd", 32'(bcdOut), 32'(f.bcd));
          chk("frame_blank", 32'(blankMask), 32'(f.blank));
          chk("frame_err", 32'(err), 32'(f.err));
          chk("frame_latency_cycle", 32'(cyc), 32'(f.at));
          h_bcd = f.bcd; h_blank = f.blank; h_err = f.err;
        end
      end else begin
        chk("hold_outputs", {11'h0, err, blankMask, bcdOut}, {11'h0, h_err, h_blank, h_bcd});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_bcd", 32'(bcdOut), 32'h0);
    chk("init_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    idle(4);

    // Reset mid-frame: partial 1234 must leave no trace.
    scan(4'hE, 7'h19, 8);
    scan(4'hD, 7'h30, 8);
    scan(4'hB, 7'h24, 8);
    idle(4);
    do_reset();
    idle(2);
    scan(4'hE, 7'h40, 8);
    scan(4'hD, 7'h40, 8);
    scan(4'hB, 7'h40, 8);
    scan(4'h7, 7'h40, 8);
    idle(4);
    chk("zero_frame_bcd", 32'(bcdOut), 32'h0000);

    // Basic frame 0123.
    scan(4'hE, 7'h30, 8);
    scan(4'hD, 7'h24, 8);
    scan(4'hB, 7'h79, 8);
    scan(4'h7, 7'h40, 8);
    idle(3);
    chk("basic_bcd", 32'(bcdOut), 32'h0123);
    chk("basic_blank", 32'(blankMask), 32'h0);
    chk("basic_err", 32'(err), 32'h0);

    // Debounce: short 5 is rejected, glitch inside a hold adds nothing.
    scan(4'hE, 7'h12, 3);
    scan(4'hE, 7'h19, 8);
    scan(4'hD, 7'h40, 8);
    scan(4'hB, 7'h78, 8);
    scan(4'hB, 7'h00, 1);
    scan(4'hB, 7'h78, 3);
    scan(4'h7, 7'h10, 8);
    idle(3);
    chk("debounce_bcd", 32'(bcdOut), 32'h9704);

    // Blank and invalid digits.
    scan(4'hE, 7'h12, 8);
    scan(4'hD, 7'h7E, 8);
    scan(4'hB, 7'h02, 8);
    scan(4'h7, 7'h7F, 8);
    idle(3);
    chk("blankinv_bcd", 32'(bcdOut), 32'hF6E5);
    chk("blankinv_mask", 32'(blankMask), 32'h8);
    chk("blankinv_err", 32'(err), 32'h1);
    scan(4'hE, 7'h79, 8);
    scan(4'hD, 7'h24, 8);
    scan(4'hB, 7'h30, 8);
    scan(4'h7, 7'h19, 8);
    idle(3);
    chk("clean_bcd", 32'(bcdOut), 32'h4321);
    chk("clean_err", 32'(err), 32'h0);

    // Illegal enables between legal scans.
    scan(4'hE, 7'h30, 8);
    scan(4'hF, 7'h00, 10);
    scan(4'hC, 7'h40, 10);
    scan(4'hD, 7'h24, 8);
    scan(4'hB, 7'h79, 8);
    scan(4'h7, 7'h40, 8);
    idle(3);
    chk("illegal_bcd", 32'(bcdOut), 32'h0123);

    // Out of order with an overwrite of digit 2.
    scan(4'hB, 7'h19, 8);
    scan(4'hE, 7'h02, 8);
    scan(4'hB, 7'h12, 8);
    scan(4'h7, 7'h10, 8);
    chk("ooo_hold_bcd", 32'(bcdOut), 32'h0123);
    scan(4'hD, 7'h78, 8);
    idle(3);
    chk("ooo_bcd", 32'(bcdOut), 32'h9576);

    // Randomized scans: random order, values, hold lengths, glitches and illegal enables.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        int r;
        logic [6:0] seg;
        logic [3:0] an;
        r = int'($urandom_range(0, 19));
        if (r < 14)      seg = pat[$urandom_range(0, 9)];
        else if (r < 16) seg = 7'h7F;
        else             seg = 7'($urandom);
        an = 4'hF;
        an[order[i]] = 1'b0;
        if ($urandom_range(0, 7) == 0) scan(4'($urandom), 7'($urandom), int'($urandom_range(1, 8)));
        scan(an, seg, int'($urandom_range(3, 10)));
        if ($urandom_range(0, 5) == 0) scan(an, 7'($urandom), 1);
      end
    end
    idle(20);
    chk("frames_outstanding", 32'(exp_q.size()), 32'h0);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
